uram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port 4096×72 URAM storage unit (`uram_unit`) between two requesters, e.g. the coefficient loader and the DFT butterfly datapath. It accepts valid/ready read and write requests and grants at most one access per cycle to the URAM. It returns read data in order to the issuing requester at a fixed two-cycle latency. An optional lock lets one requester hold the port for back-to-back bursts.

---
 rtl/uram_port_arbiter_pkg.sv | 13 +
 rtl/uram_unit.sv | 21 ++
 rtl/uram_port_arbiter.sv | 99 +++++++++
 tb/tb_uram_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uram_port_arbiter_pkg.sv
// Shared sizes and response-pipeline entry type for the URAM port arbiter.
package uram_port_arbiter_pkg;

  localparam int URAM_DATA_WIDTH = 72;
  localparam int URAM_ADDR_WIDTH = 12;
  localparam int NUM_URAM_REQ    = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_stage_t;

endpackage

// File: rtl/uram_unit.sv
// Single-port read-first URAM with a registered read output.
module uram_unit #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    data_out <= mem[addr];
    if (we)
      mem[addr] <= data_in;
  end

endmodule

// File: rtl/uram_port_arbiter.sv
// Round-robin two-requester arbiter with lock, sharing one URAM port.
module uram_port_arbiter
  import uram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = URAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = URAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  logic                  prio;
  logic                  lock_vld;
  logic                  lock_id;
  logic                  owner_hit;
  logic                  granted;
  logic                  win;
  logic                  uram_we;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] uram_addr;
  logic [DATA_WIDTH-1:0] uram_din;
  logic [DATA_WIDTH-1:0] uram_dout;
  rsp_stage_t            s1;
  rsp_stage_t            s2;

  always_comb begin
    owner_hit = lock_vld & req_valid[lock_id];
    granted   = |req_valid;
    win       = req_valid[1];
    if (owner_hit)
      win = lock_id;
    else if (&req_valid)
      win = prio;
    req_ready = 2'b00;
    if (granted)
      req_ready = win ? 2'b10 : 2'b01;
    uram_we   = granted & req_we[win];
    uram_din  = win ? req_wdata1 : req_wdata0;
    // idle cycles park the address instead of chasing requester inputs
    uram_addr = addr_q;
    if (granted)
      uram_addr = win ? req_addr1 : req_addr0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      addr_q   <= '0;
      s1       <= '0;
      s2       <= '0;
      rsp_data <= '0;
    end else begin
      if (granted) begin
        addr_q  <= uram_addr;
        lock_id <= win;
      end
      if (granted & ~owner_hit)
        prio <= ~win;
      // an absent owner implies either no grant or a new winner
      lock_vld <= granted & req_lock[win];
      s1 <= '{valid: granted & ~req_we[win], id: win};
      s2 <= s1;
      if (s1.valid)
        rsp_data <= uram_dout;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (s2.valid)
      rsp_valid = s2.id ? 2'b10 : 2'b01;
    busy = s1.valid | s2.valid;
  end

  uram_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_uram (
    .clk      (clk),
    .we       (uram_we),
    .addr     (uram_addr),
    .data_in  (uram_din),
    .data_out (uram_dout)
  );

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Randomized and directed checks of uram_port_arbiter against a reference model.
module tb_uram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [11:0] req_addr0, req_addr1;
  logic [71:0] req_wdata0, req_wdata1, rsp_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    bit          id;
    logic [71:0] data;
    bit          known;
  } exp_t;

  exp_t        q[$];
  logic [71:0] mem[int];
  int          m_prio;
  int          m_owner;

  always #5 clk = ~clk;

  uram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves at the next negedge.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [1:0] lk, input logic [11:0] a0,
                      input logic [11:0] a1, input logic [71:0] d0,
                      input logic [71:0] d1, output logic [1:0] got_rdy);
    logic [1:0] ev;
    logic [1:0] er;
    int         win;
    int         a;
    bit         hit;
    exp_t       e;
    ev = 2'b00;
    if (q.size() > 0 && q[0].due == cyc)
      ev = q[0].id ? 2'b10 : 2'b01;
    check("rsp_valid", 72'(rsp_valid), 72'(ev));
    check("busy", 72'(busy), 72'(q.size() > 0));
    if (ev != 2'b00) begin
      if (q[0].known)
        check("rsp_data", rsp_data, q[0].data);
      void'(q.pop_front());
    end
    req_valid = v; req_we = we; req_lock = lk;
    req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1;
    #1;
    win = -1;
    if (v != 2'b00) begin
      hit = (m_owner >= 0) && v[m_owner];
      if (hit)
        win = m_owner;
      else if (v == 2'b11)
        win = m_prio;
      else
        win = v[1] ? 1 : 0;
      if (!hit)
        m_prio = 1 - win;
      m_owner = lk[win] ? win : -1;
      a = int'(win ? a1 : a0);
      if (we[win]) begin
        mem[a] = win ? d1 : d0;
      end else begin
        e.due   = cyc + 2;
        e.id    = (win == 1);
        e.known = mem.exists(a);
        e.data  = e.known ? mem[a] : '0;
        q.push_back(e);
      end
    end else begin
      m_owner = -1;
    end
    er = (win < 0) ? 2'b00 : (win == 1 ? 2'b10 : 2'b01);
    got_rdy = req_ready;
    check("req_ready", 72'(req_ready), 72'(er));
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
    #1;
    check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_rsp_data", rsp_data, 72'(0));
    check("rst_ready", 72'(req_ready), 72'(0));
    q.delete();
    m_prio = 0;
    m_owner = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [1:0] r;
    for (int i = 0; i < n; i++)
      step(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 72'h0, 72'h0, r);
  endtask

  initial begin
    logic [1:0]  r;
    logic [1:0]  rv, rw, rl;
    logic [71:0] d0, d1;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    @(negedge clk);
    do_reset();

    // single read
    step(2'b01, 2'b01, 2'b00, 12'h005, 12'h0, 72'h0AB, 72'h0, r);
    step(2'b10, 2'b00, 2'b00, 12'h0, 12'h005, 72'h0, 72'h0, r);
    idle(3);

    // contention after reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 2'b00, 2'b00, 12'h005, 12'h005, 72'h0, 72'h0, r);
      check("contend", 72'(r), 72'(i % 2 == 0 ? 2'b01 : 2'b10));
    end
    idle(2);

    // lock burst by requester 1
    step(2'b01, 2'b00, 2'b00, 12'h005, 12'h0, 72'h0, 72'h0, r);
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, {k < 3, 1'b0}, 12'h005, 12'h005, 72'h0, 72'h0, r);
      check("lock_hold", 72'(r), 72'(2'b10));
    end
    step(2'b11, 2'b00, 2'b00, 12'h005, 12'h005, 72'h0, 72'h0, r);
    check("lock_after", 72'(r), 72'(2'b01));
    idle(2);

    // lock released when owner drops valid
    step(2'b01, 2'b00, 2'b01, 12'h005, 12'h0, 72'h0, 72'h0, r);
    step(2'b10, 2'b00, 2'b00, 12'h0, 12'h005, 72'h0, 72'h0, r);
    check("lock_drop", 72'(r), 72'(2'b10));
    idle(2);

    // read after write
    step(2'b01, 2'b01, 2'b00, 12'h3FF, 12'h0,
         72'hFF_0000_0000_0000_0001, 72'h0, r);
    step(2'b10, 2'b00, 2'b00, 12'h0, 12'h3FF, 72'h0, 72'h0, r);
    idle(3);

    // reset while a read is in flight
    step(2'b01, 2'b00, 2'b00, 12'h3FF, 12'h0, 72'h0, 72'h0, r);
    do_reset();
    idle(3);
    step(2'b11, 2'b00, 2'b00, 12'h005, 12'h005, 72'h0, 72'h0, r);
    check("post_rst_grant", 72'(r), 72'(2'b01));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = 2'($urandom_range(0, 3));
      rw = 2'($urandom_range(0, 3));
      rl = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
      d0 = 72'({$urandom(), $urandom(), $urandom()});
      d1 = 72'({$urandom(), $urandom(), $urandom()});
      step(rv, rw, rl, 12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)),
           d0, d1, r);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
